// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue handshake bundle: upstream {pc, instr} push side, redirect, and decode-facing head with predecode flags.
interface riscv_fetch_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_is_ctrl;
    logic        out_illegal;
    logic        out_misalign;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_is_ctrl, out_illegal, out_misalign
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_is_ctrl, out_illegal, out_misalign
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between fetch and decode, with flush and head predecode.
module riscv_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    riscv_fetch_queue_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DROP_W-1:0]            drop_count
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [6:0]       opcode;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] acc,
                                                 input logic [CNT_W-1:0]  inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + (DROP_W+1)'(inc);
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011);
    endfunction

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Full/empty come only from count; pointers alone cannot tell them apart.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid & ~full & ~bus.flush;
    assign pop   = ~empty & bus.out_ready & ~bus.flush;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= sat_add(drop_count, count);
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= bus.in_pc;
            instr_mem[wr_ptr] <= bus.in_instr;
        end
    end

    assign bus.out_pc       = pc_mem[rd_ptr];
    assign bus.out_instr    = instr_mem[rd_ptr];
    assign opcode           = instr_mem[rd_ptr][6:0];
    assign bus.out_is_ctrl  = ~empty & is_ctrl_op(opcode);
    assign bus.out_illegal  = ~empty & ~is_legal_op(opcode);
    assign bus.out_misalign = ~empty & (|pc_mem[rd_ptr][1:0]);
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_riscv_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  count;
    logic [15:0] drop_count;

    riscv_fetch_queue_if bus();

    riscv_fetch_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .count      (count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_drop;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          acc;
    bit          seen_pop;
    logic [31:0] seen_pc;

    int legal_ops[11] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23, 'h13, 'h33, 'h0F, 'h73};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input int op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_ctrl(input int op);
        return (op == 'h6F) || (op == 'h67) || (op == 'h63);
    endfunction

    // Compare every visible output against the model's current state.
    task automatic check_state(input string pfx);
        int sz = mq.size();
        chk({pfx, "_count"},    64'(count),         64'(sz));
        chk({pfx, "_in_ready"}, 64'(bus.in_ready),  64'(sz != DEPTH));
        chk({pfx, "_out_valid"},64'(bus.out_valid), 64'(sz != 0));
        chk({pfx, "_drop"},     64'(drop_count),    64'(m_drop));
        if (sz != 0) begin
            int op = int'(mq[0].ins & 32'h7F);
            chk({pfx, "_out_pc"},    64'(bus.out_pc),       64'(mq[0].pc));
            chk({pfx, "_out_instr"}, 64'(bus.out_instr),    64'(mq[0].ins));
            chk({pfx, "_is_ctrl"},   64'(bus.out_is_ctrl),  64'(ref_ctrl(op)));
            chk({pfx, "_illegal"},   64'(bus.out_illegal),  64'(!ref_legal(op)));
            chk({pfx, "_misalign"},  64'(bus.out_misalign), 64'(mq[0].pc % 4 != 0));
        end else begin
            chk({pfx, "_flags_idle"},
                64'({bus.out_is_ctrl, bus.out_illegal, bus.out_misalign}), 64'(0));
        end
    endtask

    task automatic cycle(input bit iv, input bit fl, input bit ordy,
                         input logic [31:0] pc, input logic [31:0] ins);
        bit m_push, m_pop;
        int sz;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        #1;
        check_state("cyc");
        sz       = mq.size();
        m_push   = iv && (sz != DEPTH) && !fl;
        m_pop    = (sz != 0) && ordy && !fl;
        acc      = m_push;
        seen_pop = m_pop;
        seen_pc  = bus.out_pc;
        @(posedge clk);
        if (fl) begin
            m_drop = (m_drop + sz > 65535) ? 65535 : m_drop + sz;
            mq.delete();
        end else begin
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back('{pc: pc, ins: ins});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation bound exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        int          k;
        int          guard;
        logic [31:0] exp_pc;
        bit          have;
        logic [31:0] r_pc, r_ins;

        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
        bus.in_pc = 0; bus.in_instr = 0;
        m_drop = 0;

        // Outputs held at zero while reset is asserted.
        #3;
        chk("rst_count",     64'(count), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_drop",      64'(drop_count), 0);
        chk("rst_out_pc",    64'(bus.out_pc), 0);
        chk("rst_out_instr", 64'(bus.out_instr), 0);
        chk("rst_flags",     64'({bus.out_is_ctrl, bus.out_illegal, bus.out_misalign}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 1);

        // Fill to full with decode stalled; fifth word must wait upstream.
        k = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1, 0, 0, 32'(k * 4), 32'h0000_0013);
            if (acc) k++;
        end
        #1;
        chk("t1_full_count", 64'(count), 4);
        chk("t1_in_ready",   64'(bus.in_ready), 0);
        chk("t1_accepted",   64'(k), 4);

        // Drain in order, admitting the held fifth word once space appears.
        exp_pc = 0;
        guard  = 0;
        while ((k < 5 || mq.size() != 0) && guard < 20) begin
            cycle(k < 5, 0, 1, 32'(k * 4), 32'h0000_0013);
            if (seen_pop) begin
                chk("t2_order", 64'(seen_pc), 64'(exp_pc));
                exp_pc += 4;
            end
            if (acc) k++;
            guard++;
        end
        chk("t2_drain_bound", 64'(guard < 20), 1);
        #1;
        chk("t2_count",     64'(count), 0);
        chk("t2_out_valid", 64'(bus.out_valid), 0);
        chk("t2_popped",    64'(exp_pc), 64'(32'h14));

        // Steady push+pop at count=2 across pointer wrap.
        cycle(1, 0, 0, 32'h100, 32'h0000_0033);
        cycle(1, 0, 0, 32'h104, 32'h0000_0033);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1, 32'h108 + 32'(4 * i), 32'h0000_0033);
        #1;
        chk("t3_count", 64'(count), 2);
        chk("t3_head",  64'(bus.out_pc), 64'(32'h118));

        // Flush at count=3 with a word on the input.
        cycle(1, 0, 0, 32'h200, 32'h0000_0033);
        chk("t4_pre_count", 64'(mq.size()), 3);
        cycle(1, 1, 0, 32'hDEAD_BEE0, 32'h0000_0013);
        #1;
        chk("t4_count",     64'(count), 0);
        chk("t4_out_valid", 64'(bus.out_valid), 0);
        chk("t4_drop",      64'(drop_count), 3);
        cycle(0, 0, 0, 0, 0);

        // Predecode flags on the head.
        cycle(1, 0, 0, 32'h0, 32'h0000_006F);
        cycle(1, 0, 0, 32'h4, 32'h0000_0000);
        cycle(1, 0, 0, 32'h2, 32'h0000_0013);
        #1;
        chk("t5_jal_ctrl",    64'(bus.out_is_ctrl), 1);
        chk("t5_jal_illegal", 64'(bus.out_illegal), 0);
        cycle(0, 0, 1, 0, 0);
        #1;
        chk("t5_zero_illegal", 64'(bus.out_illegal), 1);
        chk("t5_zero_ctrl",    64'(bus.out_is_ctrl), 0);
        cycle(0, 0, 1, 0, 0);
        #1;
        chk("t5_misalign",     64'(bus.out_misalign), 1);
        chk("t5_addi_illegal", 64'(bus.out_illegal), 0);
        cycle(0, 0, 1, 0, 0);

        // Asynchronous reset mid-cycle with two entries held.
        cycle(1, 0, 0, 32'h300, 32'h0000_0037);
        cycle(1, 0, 0, 32'h304, 32'h0000_0037);
        @(negedge clk);
        bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
        #1;
        chk("t6_pre_count", 64'(count), 2);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_count",     64'(count), 0);
        chk("t6_out_valid", 64'(bus.out_valid), 0);
        chk("t6_drop",      64'(drop_count), 0);
        chk("t6_out_pc",    64'(bus.out_pc), 0);
        mq.delete();
        m_drop = 0;
        @(negedge clk);
        reset = 1'b0;

        // Random traffic; upstream holds its word until accepted.
        have = 0;
        r_pc = 0;
        r_ins = 0;
        for (int c = 0; c < 1500; c++) begin
            bit fl, ordy;
            if (!have && ($urandom_range(0, 3) != 0)) begin
                have  = 1;
                r_pc  = $urandom();
                if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
                r_ins = $urandom();
                if ($urandom_range(0, 4) != 0)
                    r_ins[6:0] = 7'(legal_ops[$urandom_range(0, 10)]);
            end
            fl   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            cycle(have, fl, ordy, r_pc, r_ins);
            if (acc || fl) have = 0;
        end
        @(negedge clk);
        check_state("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
